// File: rtl/host_uart_rx.sv
// host_uart_rx: 8N1..8N16 UART receiver that samples each bit at its midpoint and pushes bytes into a host RX FIFO.
// Latency: fifo_wr_en asserts 1 clk after the mid-sample of the last stop bit; rts lags fifo_afull by 1 clk.
// Backpressure: no stall path; a byte that completes while fifo_full=1 is dropped and flagged with overrun_err.
//
// Ports:
//    clk, reset_n      rising-edge clock, asynchronous active-low reset
//    baud_nco[31:0]    NCO increment, bit rate = clk*baud_nco/2^32 (keep below 2^31)
//    stop_bit[3:0]     number of stop bits minus 1
//    flow_control      1: rts follows fifo_afull, 0: rts held at 0
//    rxd               asynchronous serial input, idle high
//    rts               active-low ready-to-receive
//    fifo_wr_en/dout   one-cycle write strobe and byte into the RX FIFO
//    fifo_full/afull   RX FIFO status
//    frame_err         one-cycle pulse, a stop bit was sampled low
//    overrun_err       one-cycle pulse, a byte was dropped because the FIFO was full
//    brk_det           one-cycle pulse on line break (only with HOST_UART_RX_BREAK_EN, else 0)
//
// Optional feature macro: HOST_UART_RX_BREAK_EN
//    Defined:   an all-zero byte with a low stop bit is reported on brk_det instead of frame_err,
//               and the receiver waits for the line to return high before hunting for a new start bit.
//    Undefined: such a frame is an ordinary frame error and brk_det is tied to 0.

module host_uart_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] baud_nco,
   input  logic [3:0]  stop_bit,
   input  logic        flow_control,
   input  logic        rxd,
   output logic        rts,
   output logic        fifo_wr_en,
   output logic [7:0]  fifo_dout,
   input  logic        fifo_full,
   input  logic        fifo_afull,
   output logic        frame_err,
   output logic        overrun_err,
   output logic        brk_det
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_t;

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_rxd_s_d1;
   logic [31:0]            r_nco;
   logic                   r_nco_msb_d1;
   state_t                 r_state;
   logic [7:0]             r_shift;
   logic [2:0]             r_data_idx;
   logic [3:0]             r_stop_idx;
   logic                   r_stop_err;
   logic                   r_fifo_wr_en;
   logic [7:0]             r_fifo_dout;
   logic                   r_frame_err;
   logic                   r_overrun_err;
   logic                   r_rts;
`ifdef HOST_UART_RX_BREAK_EN
   logic                   r_brk_det;
`endif

   // ------------------------------------------------------------------
   // Wires
   // ------------------------------------------------------------------
   logic   w_rxd_s;
   logic   w_start_edge;
   logic   w_trig;
   logic   w_last_stop;
   logic   w_stop_err_now;
   state_t w_state_nxt;
   logic   w_wr_nxt;
   logic   w_ferr_nxt;
   logic   w_ovr_nxt;
`ifdef HOST_UART_RX_BREAK_EN
   logic   w_brk_nxt;
`endif

   assign w_rxd_s      = r_sync[SYNC_STAGES-1];
   assign w_start_edge = ~w_rxd_s & r_rxd_s_d1;
   // Rising edge of the NCO MSB marks a bit midpoint once the NCO has been
   // zeroed at the start edge (half a bit after the edge, then every bit).
   assign w_trig       = r_nco[31] & ~r_nco_msb_d1;
   assign w_last_stop  = (r_stop_idx == stop_bit);
   // Error status including the stop bit being sampled this cycle, so the
   // last stop bit can be resolved on the same trig that samples it.
   assign w_stop_err_now = r_stop_err | ~w_rxd_s;

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM next state and next-cycle output pulses
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_wr_nxt    = 1'b0;
      w_ferr_nxt  = 1'b0;
      w_ovr_nxt   = 1'b0;
`ifdef HOST_UART_RX_BREAK_EN
      w_brk_nxt   = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_start_edge) begin
               w_state_nxt = ST_START;
            end
         end
         ST_START: begin
            if (w_trig) begin
               // Line back high at mid start bit: treat as a glitch.
               w_state_nxt = w_rxd_s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_trig && (r_data_idx == 3'd7)) begin
               w_state_nxt = ST_STOP;
            end
         end
         ST_STOP: begin
            if (w_trig && w_last_stop) begin
               // Leave half a bit early so a start bit right after the
               // last stop bit is not missed.
               w_state_nxt = ST_IDLE;
`ifdef HOST_UART_RX_BREAK_EN
               if (w_stop_err_now && (r_shift == 8'h00)) begin
                  w_brk_nxt   = 1'b1;
                  w_state_nxt = ST_BREAK;
               end else
`endif
               if (w_stop_err_now) begin
                  w_ferr_nxt = 1'b1;
               end else if (fifo_full) begin
                  w_ovr_nxt = 1'b1;
               end else begin
                  w_wr_nxt = 1'b1;
               end
            end
         end
         ST_BREAK: begin
            // Hold off start-bit hunting until the line is released.
            if (w_rxd_s) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Synchronizer, NCO, datapath and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync        <= '1;
         r_rxd_s_d1    <= 1'b1;
         r_nco         <= 32'd0;
         r_nco_msb_d1  <= 1'b0;
         r_shift       <= 8'd0;
         r_data_idx    <= 3'd0;
         r_stop_idx    <= 4'd0;
         r_stop_err    <= 1'b0;
         r_fifo_wr_en  <= 1'b0;
         r_fifo_dout   <= 8'd0;
         r_frame_err   <= 1'b0;
         r_overrun_err <= 1'b0;
         r_rts         <= 1'b1;
`ifdef HOST_UART_RX_BREAK_EN
         r_brk_det     <= 1'b0;
`endif
      end else begin
         r_sync     <= {r_sync[SYNC_STAGES-2:0], rxd};
         r_rxd_s_d1 <= w_rxd_s;

         // Re-phase on the start edge: the MSB then rises half a bit later.
         if ((r_state == ST_IDLE) && w_start_edge) begin
            r_nco        <= 32'd0;
            r_nco_msb_d1 <= 1'b0;
         end else begin
            r_nco        <= r_nco + baud_nco;
            r_nco_msb_d1 <= r_nco[31];
         end

         case (r_state)
            ST_START: begin
               if (w_trig && !w_rxd_s) begin
                  r_data_idx <= 3'd0;
               end
            end
            ST_DATA: begin
               if (w_trig) begin
                  r_shift[r_data_idx] <= w_rxd_s;
                  r_data_idx          <= r_data_idx + 3'd1;
                  if (r_data_idx == 3'd7) begin
                     r_stop_idx <= 4'd0;
                     r_stop_err <= 1'b0;
                  end
               end
            end
            ST_STOP: begin
               if (w_trig) begin
                  if (!w_rxd_s) begin
                     r_stop_err <= 1'b1;
                  end
                  if (!w_last_stop) begin
                     r_stop_idx <= r_stop_idx + 4'd1;
                  end
               end
            end
            default: begin
            end
         endcase

         r_fifo_wr_en  <= w_wr_nxt;
         r_frame_err   <= w_ferr_nxt;
         r_overrun_err <= w_ovr_nxt;
`ifdef HOST_UART_RX_BREAK_EN
         r_brk_det     <= w_brk_nxt;
`endif
         // Byte stays on fifo_dout until the next accepted frame.
         if (w_wr_nxt) begin
            r_fifo_dout <= r_shift;
         end

         r_rts <= flow_control & fifo_afull;
      end
   end

   assign rts         = r_rts;
   assign fifo_wr_en  = r_fifo_wr_en;
   assign fifo_dout   = r_fifo_dout;
   assign frame_err   = r_frame_err;
   assign overrun_err = r_overrun_err;
`ifdef HOST_UART_RX_BREAK_EN
   assign brk_det     = r_brk_det;
`else
   assign brk_det     = 1'b0;
`endif

endmodule

// File: doc/host_uart_rx.md
Name: host_uart_rx

Overview:
- UART receiver that pairs with the host UART transmitter: 8 data bits, LSB first, no parity, 1 to 16 stop bits.
- Bit timing comes from the same 32-bit NCO scheme as the transmitter: bit rate = clk*baud_nco/2^32.
- The NCO is re-phased on each start edge so that every bit is sampled at its midpoint.
- Received bytes are pushed into a host RX FIFO. Optional RTS flow control is driven from the FIFO almost-full flag.

Parameters:
SYNC_STAGES, 2, number of flops in the rxd synchronizer (minimum 2).

Ports:
clk  in  1  system clock; all logic on the rising edge
reset_n  in  1  asynchronous active-low reset
baud_nco  in  32  NCO increment; bit rate = clk*baud_nco/2^32; must be below 2^31
stop_bit  in  4  number of stop bits minus 1 (0 = 1 stop bit, 15 = 16 stop bits)
flow_control  in  1  1 = drive rts from FIFO level; 0 = rts held at 0
rxd  in  1  serial input, asynchronous, idle high
rts  out  1  active-low ready-to-receive (0 = peer may send)
fifo_wr_en  out  1  one-cycle write strobe into the RX FIFO
fifo_dout  out  8  received byte; valid when fifo_wr_en=1
fifo_full  in  1  RX FIFO full
fifo_afull  in  1  RX FIFO almost full
frame_err  out  1  one-cycle pulse: a stop bit was sampled as 0
overrun_err  out  1  one-cycle pulse: a byte was dropped because fifo_full=1
brk_det  out  1  one-cycle pulse on line break (optional feature); tied to 0 when the feature is compiled out

Behaviour:
Reset:
- All state is cleared and the FSM goes to ST_IDLE.
- rts=1, fifo_wr_en=0, fifo_dout=0, frame_err=0, overrun_err=0, brk_det=0.
- The synchronizer flops reset to 1.
- Reset mid-frame abandons the frame with no write and no error pulse.

Synchronizer and edge detect:
- rxd passes through SYNC_STAGES flops to give rxd_s; rxd_s_d1 is rxd_s delayed by one cycle.
- A start edge is rxd_s=0 and rxd_s_d1=1.

NCO:
- nco <= nco + baud_nco every cycle; trig = nco[31] & ~nco_msb_d1.
- On a start edge in ST_IDLE, nco and nco_msb_d1 are both loaded with 0.
- The first trig therefore falls half a bit after the edge (mid start bit); each later trig is one full bit later.

FSM:
- ST_IDLE: on a start edge, go to ST_START.
- ST_START, on trig:
  - rxd_s=1: false start, return to ST_IDLE silently.
  - rxd_s=0: go to ST_DATA with data_idx=0.
- ST_DATA, on trig:
  - Shift register bit [data_idx] <= rxd_s; data_idx increments.
  - After bit 7 (data_idx wraps from 7 to 0), go to ST_STOP with stop_idx=0 and a cleared stop-error flag.
- ST_STOP, on trig:
  - Sample rxd_s; a 0 sets the stop-error flag.
  - If stop_idx != stop_bit, increment stop_idx and stay.
  - If stop_idx == stop_bit, this is the last stop bit; resolve it on the next clk and go to ST_IDLE.
- Last-stop-bit resolution, evaluated in this priority order:
  1. Stop-error flag set: frame_err=1 for 1 cycle; byte discarded.
  2. Else fifo_full=1: overrun_err=1 for 1 cycle; byte discarded.
  3. Else fifo_wr_en=1 for exactly 1 cycle with fifo_dout=byte.
- fifo_dout holds its value until the next write.

Timing rules:
- ST_IDLE is re-entered half a bit before the end of the last stop bit, so a start bit immediately after the stop bit(s) is caught.
- Back-to-back frames produce no lost bytes.
- The start-edge search is only active in ST_IDLE; edges in other states are ignored.
- Latency: fifo_wr_en asserts 1 clk after the mid-sample trig of the last stop bit.

RTS:
- Registered: rts <= flow_control & fifo_afull.
- This gives 1 cycle of latency from fifo_afull and is independent of FSM state.

Optional Feature:
Macro: HOST_UART_RX_BREAK_EN
- Defined:
  - At last-stop-bit resolution, a break is a frame whose byte is 0x00 and whose stop-error flag is set.
  - On a break: brk_det=1 for 1 cycle, frame_err stays 0, no write, and the FSM enters ST_BREAK.
  - ST_BREAK waits for rxd_s=1, then returns to ST_IDLE; no start edge is accepted while in ST_BREAK.
- Not defined:
  - A break is an ordinary frame error (frame_err pulse) and the FSM returns to ST_IDLE.
  - brk_det is tied to 0.

Test Plan:
(All scenarios use baud_nco=32'h1000_0000, i.e. 16 clk per bit; flow_control=0; FIFO empty unless stated.)
1. stop_bit=0, send 0xA5 -> exactly one fifo_wr_en pulse with fifo_dout=0xA5, about 152 clk after the start edge; frame_err=0, overrun_err=0.
2. stop_bit=1, send 0x3C then 0xC3 back-to-back (2 stop bits, no idle gap) -> two writes, 0x3C then 0xC3, no errors.
3. stop_bit=1, send 0x5A with the second stop bit driven 0 -> frame_err pulse, no fifo_wr_en; next frame 0x11 is received correctly.
4. rxd low for 4 clk then high (glitch) -> FSM returns to ST_IDLE at the mid-start trig; no write, no error pulses.
5. fifo_full=1 during 0x77 -> overrun_err pulse, no fifo_wr_en. Also: assert reset_n=0 mid-data -> all outputs return to reset values, and a following 0x42 is received correctly.
6. flow_control=1, toggle fifo_afull -> rts follows 1 clk later; flow_control=0 -> rts=0. With HOST_UART_RX_BREAK_EN defined, hold rxd low for 12 bit times -> one brk_det pulse, frame_err=0; after rxd returns high, 0x55 is received correctly.
